// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM states, grant encoding,
// store payload layout and starvation counter sizing.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_e;

    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_wr_t;

    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between IF and DM, with a saturating count of consecutive
// DM grants taken while IF was waiting.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic gnt_stb,
    output logic gnt_dm
);

    localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    // DM wins unless IF has already been passed over LIMIT times in a row
    always_comb begin
        gnt_dm = dm_req && !(if_req && (starve_cnt_q == LIMIT));
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_stb) begin
            if (gnt_dm && if_req) begin
                starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Schedules IF fetches and DM loads/stores onto the single memory port using
// a req/ack handshake; one access in flight, ready pulses back to requesters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [MASK_W-1:0] dm_wmask,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q,    state_d;
    gnt_e              gnt_q,      gnt_d;
    logic              mem_req_q,  mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    mem_wr_t           mem_wr_q,   mem_wr_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              busy_q,     busy_d;
    logic              gnt_stb_c;
    logic              gnt_dm;

    // Arbitration only ever happens from IDLE
    assign gnt_stb_c = (state_q == IDLE) && (if_req || dm_req);

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .gnt_stb (gnt_stb_c),
        .gnt_dm  (gnt_dm)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_wr_d   = mem_wr_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_stb_c) begin
                    state_d   = ACCESS;
                    mem_req_d = 1'b1;
                    if (gnt_dm) begin
                        gnt_d          = GNT_DM;
                        mem_addr_d     = dm_addr;
                        mem_wr_d.wdata = dm_wdata;
                        mem_wr_d.wmask = dm_we ? dm_wmask : '0;
                    end else begin
                        gnt_d      = GNT_IF;
                        mem_addr_d = if_addr;
                        mem_wr_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (gnt_q == GNT_DM) begin
                        dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_wr_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_q   <= mem_wr_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wr_q.wdata;
    assign mem_wmask = mem_wr_q.wmask;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses are queued in
// service order, checked at the memory port on ack and again on ready.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;

    typedef struct {
        bit          dm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [31:0]       dm_wdata = '0;
    logic [3:0]        dm_wmask = '0;
    logic [31:0]       dm_rdata;
    logic              dm_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              busy;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bit   resp_en = 1'b0;
    int   mem_wait = 0;
    int   wcnt = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit dm, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        exp_t e;
        e.dm = dm; e.addr = a; e.wdata = wd; e.wmask = wm;
        exp_q.push_back(e);
    endtask

    // Memory model: acks after mem_wait idle ACCESS cycles, checks the command
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    wcnt = 0;
                end else if (mem_req) begin
                    if (wcnt == mem_wait) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL mem_cmd: access addr %h with nothing expected", mem_addr);
                        end else if (mem_addr !== exp_q[0].addr || mem_wmask !== exp_q[0].wmask ||
                                     (exp_q[0].dm && mem_wdata !== exp_q[0].wdata)) begin
                            n_err++;
                            $display("FAIL mem_cmd: got addr %h wdata %h wmask %b, want addr %h wdata %h wmask %b",
                                     mem_addr, mem_wdata, mem_wmask,
                                     exp_q[0].addr, exp_q[0].wdata, exp_q[0].wmask);
                        end
                        mem_rdata = model_rdata(mem_addr);
                        mem_ack = 1'b1;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // Completion monitor: every ready pulse must match the head of the queue
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (rst && (if_ready || dm_ready)) begin
                n_vec++;
                if (if_ready && dm_ready) begin
                    n_err++;
                    $display("FAIL ready_both: if_ready=1 dm_ready=1, want one-hot");
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ready_unexp: if_ready=%0b dm_ready=%0b, want none", if_ready, dm_ready);
                end else begin
                    e = exp_q.pop_front();
                    if (e.dm) exp_dm_rdata = model_rdata(e.addr);
                    else      exp_if_rdata = model_rdata(e.addr);
                    if (dm_ready !== e.dm) begin
                        n_err++;
                        $display("FAIL ready_side: dm_ready=%0b, want %0b", dm_ready, e.dm);
                    end else if ((e.dm ? dm_rdata : if_rdata) !== model_rdata(e.addr)) begin
                        n_err++;
                        $display("FAIL rdata: got %h, want %h", e.dm ? dm_rdata : if_rdata, model_rdata(e.addr));
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) tick();
        n_vec++;
        if ({mem_req, busy, if_ready, dm_ready, mem_wmask} !== 8'h00 ||
            mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_outs: req=%0b busy=%0b addr=%h wdata=%h ifr=%h dmr=%h, want all 0",
                     mem_req, busy, mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%0b mem_req=%0b, want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        resp_en = 1'b0;
        if_addr = 32'h40;
        if_req = 1'b1;
        tick();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rma_access: req=%0b addr=%h busy=%0b, want 1 00000040 1", mem_req, mem_addr, busy);
        end
        tick();
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({mem_req, busy, if_ready, dm_ready, mem_wmask} !== 8'h00 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL rma_async: req=%0b busy=%0b addr=%h, want 0 0 0", mem_req, busy, mem_addr);
        end
        if_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        mem_rdata = 32'hCAFE_F00D;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if (if_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rma_late_ack: if_ready=%0b busy=%0b, want 0 0", if_ready, busy);
        end
        tick();
        n_vec++;
        if (if_ready !== 1'b0 || busy !== 1'b0 || if_rdata !== exp_if_rdata) begin
            n_err++;
            $display("FAIL rma_after: if_ready=%0b busy=%0b if_rdata=%h, want 0 0 %h",
                     if_ready, busy, if_rdata, exp_if_rdata);
        end
    endtask

    task automatic test_single_load();
        resp_en = 1'b1;
        mem_wait = 0;
        push(1'b1, 32'h100, 32'h1111_1111, 4'b0000);
        dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h1111_1111; dm_wmask = 4'hF;
        dm_req = 1'b1;
        tick();
        n_vec++;
        if (mem_req !== 1'b1 || mem_wmask !== 4'b0000 || mem_addr !== 32'h100 || dm_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_c1: req=%0b wmask=%b addr=%h rdy=%0b, want 1 0000 00000100 0",
                     mem_req, mem_wmask, mem_addr, dm_ready);
        end
        tick();
        n_vec++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL load_c2: dm_ready=%0b dm_rdata=%h, want 1 deadbeef", dm_ready, dm_rdata);
        end
        dm_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_store_wait();
        resp_en = 1'b1;
        mem_wait = 3;
        push(1'b1, 32'h204, 32'h00AB_00AB, 4'b0100);
        dm_we = 1'b1; dm_addr = 32'h204; dm_wdata = 32'h00AB_00AB; dm_wmask = 4'b0100;
        dm_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_vec++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'h00AB_00AB ||
                mem_wmask !== 4'b0100 || dm_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL store_hold c%0d: req=%0b addr=%h wdata=%h wmask=%b rdy=%0b busy=%0b, want 1 204 00ab00ab 0100 0 1",
                         c, mem_req, mem_addr, mem_wdata, mem_wmask, dm_ready, busy);
            end
        end
        tick();
        n_vec++;
        if (dm_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL store_c5: dm_ready=%0b mem_req=%0b, want 1 0", dm_ready, mem_req);
        end
        dm_req = 1'b0;
        dm_we = 1'b0;
        mem_wait = 0;
        repeat (2) tick();
    endtask

    task automatic test_collision();
        resp_en = 1'b1;
        mem_wait = 0;
        push(1'b1, 32'h300, 32'h0, 4'b0000);
        push(1'b0, 32'h1000, 32'h0, 4'b0000);
        dm_we = 1'b0; dm_addr = 32'h300; dm_wdata = 32'h0;
        if_addr = 32'h1000;
        dm_req = 1'b1;
        if_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_vec++;
            if (dm_ready !== (c == 2) || if_ready !== (c == 5)) begin
                n_err++;
                $display("FAIL collide c%0d: dm_ready=%0b if_ready=%0b, want %0b %0b",
                         c, dm_ready, if_ready, c == 2, c == 5);
            end
            if (c == 2) dm_req = 1'b0;
            if (c == 5) if_req = 1'b0;
        end
        repeat (2) tick();
    endtask

    task automatic test_starvation();
        resp_en = 1'b1;
        mem_wait = 0;
        for (int i = 0; i < 4; i++) push(1'b1, 32'h400, 32'h5555_AAAA, 4'b0000);
        push(1'b0, 32'h2000, 32'h0, 4'b0000);
        push(1'b1, 32'h400, 32'h5555_AAAA, 4'b0000);
        dm_we = 1'b0; dm_addr = 32'h400; dm_wdata = 32'h5555_AAAA; dm_wmask = 4'hF;
        if_addr = 32'h2000;
        dm_req = 1'b1;
        if_req = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            bit want_dm;
            tick();
            want_dm = (c == 2 || c == 5 || c == 8 || c == 11 || c == 17);
            n_vec++;
            if (dm_ready !== want_dm || if_ready !== (c == 14)) begin
                n_err++;
                $display("FAIL starve c%0d: dm_ready=%0b if_ready=%0b, want %0b %0b",
                         c, dm_ready, if_ready, want_dm, c == 14);
            end
            if (c == 14) if_req = 1'b0;
            if (c == 17) dm_req = 1'b0;
        end
        repeat (2) tick();
    endtask

    task automatic test_stray_ack();
        resp_en = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stray_state: busy=%0b mem_req=%0b if_ready=%0b dm_ready=%0b, want 0 0 0 0",
                     busy, mem_req, if_ready, dm_ready);
        end
        tick();
        n_vec++;
        if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stray_rdata: if_rdata=%h dm_rdata=%h busy=%0b, want %h %h 0",
                     if_rdata, dm_rdata, busy, exp_if_rdata, exp_dm_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_single_load();
        test_store_wait();
        test_collision();
        test_starvation();
        test_stray_ack();
        repeat (3) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d accesses outstanding, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified 32-bit memory between two requesters: instruction fetch (IF, read-only) and the memory stage (DM, load/store).
- DM supplies pre-formatted byte-lane write mask and write data; this block only schedules and sequences accesses.
- Sits between the pipeline stages and the memory macro. Variable memory latency is handled through a req/ack handshake, with per-requester ready pulses that the hazard unit uses to release stalls.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive DM grants while IF is waiting before IF is forced a grant (1..15).
- ADDR_W, 32: address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_ready.
- if_addr  input  ADDR_W  fetch address, word-aligned; stable while if_req.
- if_rdata  output  32  fetched word; valid while if_ready.
- if_ready  output  1  one-cycle completion pulse for IF.
- dm_req  input  1  data request; held until dm_ready.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  ADDR_W  data address; stable while dm_req.
- dm_wdata  input  32  lane-replicated store data.
- dm_wmask  input  4  store byte-lane mask.
- dm_rdata  output  32  raw load word; valid while dm_ready.
- dm_ready  output  1  one-cycle completion pulse for DM.
- mem_req  output  1  memory access in progress; held until mem_ack.
- mem_addr  output  ADDR_W  access address.
- mem_wdata  output  32  store data.
- mem_wmask  output  4  write lanes; 4'b0000 for reads.
- mem_ack  input  1  one-cycle; read data valid or write committed.
- mem_rdata  input  32  read data, sampled on mem_ack.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output 0; starve_cnt=0; any in-flight access is abandoned. A late mem_ack after reset is ignored.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE, with at least one request pending:
  - Grant DM if dm_req && !(if_req && starve_cnt==STARVE_LIMIT); otherwise grant IF.
  - Latch the granted address, wdata and mask into the mem_* registers. For IF and for DM loads, mem_wmask=0.
  - Set mem_req=1 and go to ACCESS.
- IDLE, no request: stay in IDLE with mem_req=0.
- ACCESS:
  - Hold mem_req and all mem_* outputs stable until mem_ack.
  - On mem_ack: mem_req=0; capture mem_rdata into the granted side's rdata register; go to RESP with that side's ready=1.
- RESP:
  - The ready pulse is high for exactly this cycle. No arbitration happens in RESP, so the requester's still-high req cannot be re-granted.
  - Next state is IDLE, with ready=0.
- if_rdata/dm_rdata hold their last captured value until the next completion for that side.
- Latency with zero-wait memory (ack in the first ACCESS cycle):
  - req sampled in IDLE at cycle 0, mem_req=1 at cycle 1, ready=1 at cycle 2.
  - Throughput is one access per 3 cycles. Each extra wait cycle adds one.
- Starvation counter:
  - On each DM grant while if_req=1: increment, saturating at STARVE_LIMIT.
  - On any IF grant: reset to 0.
  - DM grant with if_req=0: reset to 0.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_LIMIT: DM wins.
- Requests arriving during ACCESS or RESP are not sampled until IDLE.
- A requester dropping req before ready is a protocol violation. The granted access still completes and still pulses ready.
- mem_ack in IDLE or RESP: ignored; no state change.
- Stores: mem_wdata/mem_wmask are passed through unchanged. A store completes with dm_ready; dm_rdata is updated with mem_rdata (don't-care content).
- No timeout: ACCESS waits for mem_ack indefinitely, with busy=1.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}.
  - grant encoding {GNT_IF, GNT_DM}.
  - starve counter width, $clog2(STARVE_LIMIT+1).
- One sub-module, mem_arb_grant: combinational grant decision plus the starvation counter register. Inputs: if_req, dm_req, grant-strobe. Output: gnt_dm.
- Top module holds the FSM, the mem_* registers and the rdata/ready registers.

Test Plan:
- Reset mid-access: if_req, addr 0x40; mem_ack withheld; assert rst=0 in ACCESS → all outputs 0 immediately. After release, mem_ack=1 → no if_ready; busy=0.
- Single load, zero-wait: dm_req, dm_we=0, dm_addr=0x100, mem_rdata=0xDEADBEEF → mem_req at cycle 1 with mem_wmask=0; dm_ready with dm_rdata=0xDEADBEEF at cycle 2.
- Store, 3 wait cycles: dm_we=1, addr=0x204, wdata=0x00AB00AB, wmask=4'b0100 → mem_* held for 4 ACCESS cycles; dm_ready at cycle 5.
- Collision: if_req and dm_req both high at cycle 0 → DM served first (dm_ready at cycle 2), IF next (if_ready at cycle 5).
- Starvation, STARVE_LIMIT=4: dm_req and if_req held continuously → exactly 4 DM grants, then 1 IF grant, then DM again. if_ready at cycle 14.
- Stray ack: mem_ack pulses while in IDLE → no ready pulse, state stays IDLE, rdata registers unchanged.
